// File: rtl/i2s_rx_if.sv
// Stereo I2S receive bus: serial word-select/data in, parallel stereo pair out.
interface i2s_rx_if #(
  parameter int WIDTH = 24
);
  logic             lrclk;
  logic             sdin;
  logic [WIDTH-1:0] data_l;
  logic [WIDTH-1:0] data_r;
  logic             dvalid;
  logic             err;

  modport master (
    output lrclk, sdin,
    input  data_l, data_r, dvalid, err
  );

  modport slave (
    input  lrclk, sdin,
    output data_l, data_r, dvalid, err
  );
endinterface

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S / left-justified receiver; emits complete L/R pairs
// with a one-cycle dvalid strobe and flags short slots on err.
module i2s_rx_stereo #(
  parameter int WIDTH = 24,
  parameter int MODE  = 0
) (
  input logic     sclk,
  input logic     rst,
  i2s_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             prev_lr;
  logic             chan;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] hold_l;
  logic             left_ok;

  logic edge_det;
  logic last;
  logic start;
  logic shift_en;
  logic complete;
  logic frame_err;

  assign edge_det = bus.lrclk != prev_lr;
  assign last     = cnt == CW'(WIDTH - 1);
  assign word     = {sr, bus.sdin};

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    complete  = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (edge_det) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (edge_det) begin
          start   = 1'b1;
          state_n = SHIFT;
          // In I2S mode the LSB may share its cycle with the next edge
          if (MODE == 0 && last) begin
            shift_en = 1'b1;
            complete = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          shift_en = 1'b1;
          if (last) begin
            complete = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        if (edge_det) begin
          start   = 1'b1;
          state_n = SHIFT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    prev_lr <= bus.lrclk;
    if (rst) begin
      chan       <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      hold_l     <= '0;
      left_ok    <= 1'b0;
      bus.data_l <= '0;
      bus.data_r <= '0;
      bus.dvalid <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.dvalid <= 1'b0;
      bus.err    <= frame_err;
      if (shift_en || (start && MODE == 1))
        sr <= word[WIDTH-2:0];
      if (start) begin
        chan <= bus.lrclk;
        cnt  <= (MODE == 1) ? CW'(1) : '0;
      end else if (shift_en) begin
        cnt <= cnt + 1'b1;
      end
      if (frame_err)
        left_ok <= 1'b0;
      if (complete) begin
        if (!chan) begin
          hold_l  <= word;
          left_ok <= 1'b1;
        end else begin
          left_ok <= 1'b0;
          if (left_ok) begin
            bus.data_l <= hold_l;
            bus.data_r <= word;
            bus.dvalid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
